wtm_mac_accumulator: RTL
========================

// Module: wtm_mac_accumulator
// PURPOSE
//   Downstream consumer of the 5x5 Wallace-tree multiplier (WTM). Takes 10-bit products plus carry-out
//   over a valid/ready handshake and sums N_TERMS of them into a dot-product result.
//   Holds the result until the sink accepts it. Turns the combinational WTM into a sequential MAC stage.
// PARAMETERS
//   N_TERMS  4   products summed per result (>=1)
//   ACC_W    12  accumulator / result width (default holds 4*961=3844 without overflow)
// PORTS
//   clock         in   1      rising-edge clock
//   reset         in   1      asynchronous, active-high; clears all state
//   in_valid      in   1      product beat valid
//   in_ready      out  1      stage can accept a product beat
//   product       in   10     WTM product out[9:0]
//   product_cout  in   1      WTM cout; must be 0 for legal 5x5 products
//   acc_clear     in   1      synchronous abort/clear
//   out_valid     out  1      result valid
//   out_ready     in   1      sink accepts result
//   acc_out       out  ACC_W  accumulated sum
//   term_count    out  $clog2(N_TERMS+1)  products accepted in current result
//   overflow      out  1      sticky: sum exceeded 2**ACC_W-1 during current result
//   cout_err      out  1      sticky: an accepted beat had product_cout=1
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; out_valid=0; acc_out=0; term_count=0; overflow=0; cout_err=0.
//   Accept = in_valid & in_ready. Complete = out_valid & out_ready.
//   States:
//     IDLE : in_ready=1.
//            accept -> acc_out<=product (zero-extended); term_count<=1.
//            Next state: DONE if N_TERMS==1, else ACCUM.
//     ACCUM: in_ready=1.
//            accept -> acc_out<=acc_out+product; term_count++.
//            The accept that brings term_count to N_TERMS -> DONE.
//     DONE : in_ready=0; out_valid=1; acc_out, term_count and flags held stable.
//            complete -> IDLE and clears acc_out, term_count, overflow, cout_err.
//   Latency: out_valid rises the cycle after the N_TERMS-th accept.
//            Minimum N_TERMS+1 cycles per result; the cycle after complete accepts again.
//   in_valid low in IDLE/ACCUM: no change. out_ready is ignored outside DONE.
//   Sum is computed ACC_W+1 wide. If the carry bit is set: overflow<=1, and acc_out follows the
//   CONFIGURATION rule.
//   product_cout=1 on accept: cout_err<=1; only product[9:0] is added (cout not summed).
//   acc_clear (any state) has priority over accept/complete:
//     next state IDLE; acc_out, term_count and flags cleared.
//     A beat presented the same cycle is dropped (in_ready still 1 that cycle, but no accept).
//     out_valid deasserts the next cycle.
//   Reset asserted mid-result: immediate return to reset values; the partial sum is lost.
// CONFIGURATION
//   WTM_MAC_SAT_EN defined: on overflow, acc_out clamps to 2**ACC_W-1 and stays clamped for
//     the rest of the result; later adds do not wrap.
//   Not defined (default): acc_out wraps modulo 2**ACC_W; overflow flag still set.
// TESTING
//   1. Reset, then N_TERMS=4 beats 0 (0*20), 400 (25*16), 31 (31*1), 961 (31*31), in_valid held high:
//      -> in_ready low after 4th; out_valid next cycle; acc_out=1392; term_count=4; flags 0.
//   2. Same stream with out_ready low 5 cycles:
//      -> acc_out stays 1392 and in_ready=0 throughout; on out_ready=1 -> IDLE, acc_out=0 next cycle.
//   3. ACC_W=11, beats 961,961,961,0:
//      -> default: acc_out=835, overflow=1.
//      -> with WTM_MAC_SAT_EN: acc_out=2047, overflow=1.
//   4. Two beats 400,31, then acc_clear=1 together with in_valid/product=961:
//      -> next cycle IDLE, acc_out=0, term_count=0; the 961 beat is not counted.
//   5. Beat product=5 with product_cout=1:
//      -> cout_err=1 and acc_out=5; both cleared after the result completes.
//   6. Assert reset asynchronously mid-ACCUM (term_count=2):
//      -> all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/wtm_mac_accumulator.sv
// Sequential MAC stage after the 5x5 Wallace-tree multiplier: sums N_TERMS products per result.
// Optional feature macro: WTM_MAC_SAT_EN (saturate on overflow instead of wrapping).
module wtm_mac_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12,
  localparam int CNT_W  = $clog2(N_TERMS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       product,
  input  logic             product_cout,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] term_count,
  output logic             overflow,
  output logic             cout_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               cerr_q, cerr_d;
  logic [ACC_W:0]     sum;
  logic               accept;

  assign in_ready   = (state_q != DONE);
  assign out_valid  = (state_q == DONE);
  assign accept     = in_valid & in_ready;
  assign acc_out    = acc_q;
  assign term_count = cnt_q;
  assign overflow   = ovf_q;
  assign cout_err   = cerr_q;

  // One bit wider than the accumulator so the carry out of the add becomes the overflow flag.
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(product);

  // NOTE: every always_comb output takes its hold value first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    cerr_d  = cerr_q;

    if (acc_clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      cerr_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = ACC_W'(product);
            cnt_d   = CNT_W'(1);
            cerr_d  = product_cout;
            state_d = (N_TERMS == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            ovf_d  = ovf_q | sum[ACC_W];
            cerr_d = cerr_q | product_cout;
            cnt_d  = cnt_q + CNT_W'(1);
`ifdef WTM_MAC_SAT_EN
            // Once clamped, the result stays pinned at full scale until it is drained.
            if (sum[ACC_W] || ovf_q) acc_d = '1;
            else                     acc_d = sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            if (cnt_q == CNT_W'(N_TERMS - 1)) state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            cerr_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      cerr_q  <= cerr_d;
    end
  end

endmodule
